// File: rtl/shift_right_seq_if.sv
// Handshake and data bundle for the sequential right-shift unit.
// The master drives start/operands and the slave returns the result and status.
interface shift_right_seq_if #(
    parameter int unsigned N = 8
);
    localparam int unsigned AW = $clog2(N + 1);

    logic          start_i;
    logic [N-1:0]  data_i;
    logic [AW-1:0] amount_i;
    logic          arith_i;
    logic [N-1:0]  data_o;
    logic          carry_o;
    logic          busy_o;
    logic          done_o;

    modport master (
        output start_i, data_i, amount_i, arith_i,
        input  data_o, carry_o, busy_o, done_o
    );

    modport slave (
        input  start_i, data_i, amount_i, arith_i,
        output data_o, carry_o, busy_o, done_o
    );
endinterface

// File: rtl/shift_right_seq.sv
// Sequential right-shift unit: loads a word, then shifts it right one bit per
// clock (logical or arithmetic) for a clamped count, with start/busy/done
// handshake and a carry-out holding the last bit shifted out of bit 0.
module shift_right_seq #(
    parameter int unsigned N = 8
) (
    input logic             clk_i,
    input logic             rst_ni,
    shift_right_seq_if.slave bus
);
    localparam int unsigned AW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e        state_q;
    logic [N-1:0]  data_q;
    logic [AW-1:0] cnt_q;
    logic          carry_q;
    logic          arith_q;
    logic          busy_q;
    logic          done_q;
    logic [AW-1:0] amt_clamped;
    logic          fill;

    // Counts above N would only keep replicating the fill bit, so clamp them to N.
    always_comb begin
        amt_clamped = bus.amount_i;
        if (bus.amount_i > AW'(N)) begin
            amt_clamped = AW'(N);
        end
    end

    // Bit entering at the MSB: sign copy for arithmetic, zero for logical.
    always_comb begin
        fill = arith_q ? data_q[N-1] : 1'b0;
    end

    // Control FSM and datapath; busy/done are registered decodes of the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            arith_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus.start_i) begin
                        data_q  <= bus.data_i;
                        carry_q <= 1'b0;
                        cnt_q   <= amt_clamped;
                        arith_q <= bus.arith_i;
                        if (amt_clamped != '0) begin
                            state_q <= StShift;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                StShift: begin
                    // start_i is deliberately ignored while shifting.
                    data_q  <= {fill, data_q[N-1:1]};
                    carry_q <= data_q[0];
                    cnt_q   <= cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_o  = data_q;
    assign bus.carry_o = carry_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
endmodule

// File: tb/tb_shift_right_seq.sv
// Directed self-checking bench for shift_right_seq (N=8).
module tb_shift_right_seq;
    localparam int unsigned N = 8;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   failures;

    shift_right_seq_if #(.N(N)) bus ();

    shift_right_seq #(.N(N)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for done_o at negedges, counting busy cycles; bounded to avoid hangs.
    task automatic wait_done(input string tag, output int cycles, output int busy_cnt);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            cycles++;
            if (bus.done_o) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy_o) busy_cnt++;
        end
        check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // One full operation from IDLE with expected result, carry and shift count.
    task automatic run_op(input string tag, input logic [7:0] d, input logic [3:0] amt,
                          input logic ar, input logic [7:0] exp_d, input logic exp_c,
                          input int exp_k);
        int cycles;
        int busy_cnt;
        @(posedge clk_i);
        #1;
        bus.start_i  = 1'b1;
        bus.data_i   = d;
        bus.amount_i = amt;
        bus.arith_i  = ar;
        @(posedge clk_i);
        #1;
        bus.start_i  = 1'b0;
        bus.data_i   = 8'h00;
        bus.amount_i = 4'd0;
        bus.arith_i  = 1'b0;
        wait_done(tag, cycles, busy_cnt);
        check_eq({tag, "_latency"}, 32'(cycles), 32'(exp_k + 1));
        check_eq({tag, "_busy"}, 32'(busy_cnt), 32'(exp_k));
        check_eq({tag, "_data"}, 32'(bus.data_o), 32'(exp_d));
        check_eq({tag, "_carry"}, 32'(bus.carry_o), 32'(exp_c));
        @(negedge clk_i);
        check_eq({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
        check_eq({tag, "_hold"}, 32'(bus.data_o), 32'(exp_d));
    endtask

    initial begin
        int cycles;
        int busy_cnt;
        checks       = 0;
        failures     = 0;
        rst_ni       = 1'b0;
        bus.start_i  = 1'b0;
        bus.data_i   = 8'h00;
        bus.amount_i = 4'd0;
        bus.arith_i  = 1'b0;

        repeat (2) @(negedge clk_i);
        check_eq("rst_data", 32'(bus.data_o), 32'h0);
        check_eq("rst_carry", 32'(bus.carry_o), 32'h0);
        check_eq("rst_busy", 32'(bus.busy_o), 32'h0);
        check_eq("rst_done", 32'(bus.done_o), 32'h0);
        rst_ni = 1'b1;

        run_op("logical", 8'hB4, 4'd3, 1'b0, 8'h16, 1'b1, 3);
        run_op("arith", 8'hB4, 4'd2, 1'b1, 8'hED, 1'b0, 2);
        run_op("zero", 8'h5A, 4'd0, 1'b0, 8'h5A, 1'b0, 0);
        run_op("clamp_ar", 8'h80, 4'd12, 1'b1, 8'hFF, 1'b1, 8);
        run_op("clamp_lg", 8'h80, 4'd12, 1'b0, 8'h00, 1'b1, 8);
        run_op("exact_n", 8'hC3, 4'd8, 1'b0, 8'h00, 1'b1, 8);

        // start_i held through SHIFT with changed operands: ignored until DONE.
        @(posedge clk_i);
        #1;
        bus.start_i  = 1'b1;
        bus.data_i   = 8'hB4;
        bus.amount_i = 4'd3;
        bus.arith_i  = 1'b0;
        @(posedge clk_i);
        #1;
        bus.data_i   = 8'h0F;
        bus.amount_i = 4'd1;
        wait_done("hs_first", cycles, busy_cnt);
        check_eq("hs_first_busy", 32'(busy_cnt), 32'd3);
        check_eq("hs_first_data", 32'(bus.data_o), 32'h16);
        check_eq("hs_first_carry", 32'(bus.carry_o), 32'h1);
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        @(negedge clk_i);
        check_eq("hs_b2b_busy", 32'(bus.busy_o), 32'h1);
        check_eq("hs_b2b_load", 32'(bus.data_o), 32'h0F);
        check_eq("hs_b2b_carry0", 32'(bus.carry_o), 32'h0);
        @(negedge clk_i);
        check_eq("hs_b2b_done", 32'(bus.done_o), 32'h1);
        check_eq("hs_b2b_data", 32'(bus.data_o), 32'h07);
        check_eq("hs_b2b_carry", 32'(bus.carry_o), 32'h1);

        // Asynchronous reset in the middle of a shift.
        @(posedge clk_i);
        #1;
        bus.start_i  = 1'b1;
        bus.data_i   = 8'hB4;
        bus.amount_i = 4'd8;
        bus.arith_i  = 1'b1;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("mid_busy", 32'(bus.busy_o), 32'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_data", 32'(bus.data_o), 32'h0);
        check_eq("arst_carry", 32'(bus.carry_o), 32'h0);
        check_eq("arst_busy", 32'(bus.busy_o), 32'h0);
        check_eq("arst_done", 32'(bus.done_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op("post_rst", 8'h81, 4'd1, 1'b1, 8'hC0, 1'b1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
